// File: rtl/kyber_pkg.sv
// Shared types, default parameters and modular add/sub/halve helpers for the butterfly datapath.
package kyber_pkg;

    typedef enum logic [1:0] {
        ModeNtt    = 2'd0,
        ModeIntt   = 2'd1,
        ModeMult   = 2'd2,
        ModeAddsub = 2'd3
    } mode_e;

    localparam int unsigned KyberW = 12;
    localparam int unsigned KyberQ = 3329;

    // Operands are held in 32 bits so one function serves any W; callers truncate back to W.
    function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] q);
        logic [31:0] s;
        s = a + b;
        if (s >= q) begin
            s = s - q;
        end
        return s;
    endfunction

    function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] q);
        return (a >= b) ? (a - b) : (a + q - b);
    endfunction

    // x/2 mod q for odd q: add q first when x is odd so the shift is exact.
    function automatic logic [31:0] mod_half(input logic [31:0] x, input logic [31:0] q);
        return x[0] ? ((x + q) >> 1) : (x >> 1);
    endfunction

endpackage

// File: rtl/butterfly_unit_p_if.sv
// Beat-level handshake and data bundle between the NTT/PWM controller and the butterfly unit.
interface butterfly_unit_p_if #(
    parameter int unsigned W     = 12,
    parameter int unsigned LANES = 2
) ();
    import kyber_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    mode_e                mode;
    logic                 half;
    logic [LANES*W-1:0]   in_a;
    logic [LANES*W-1:0]   in_b;
    logic [LANES*W-1:0]   coef;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   out_1;
    logic [LANES*W-1:0]   out_2;

    modport slave (
        input  in_valid, mode, half, in_a, in_b, coef, out_ready,
        output in_ready, out_valid, out_1, out_2
    );

    modport master (
        output in_valid, mode, half, in_a, in_b, coef, out_ready,
        input  in_ready, out_valid, out_1, out_2
    );

endinterface

// File: rtl/mod_mul_pipe.sv
// Stall-able modular multiplier: r = x*y mod Q, MUL_LAT enabled cycles after x/y are sampled.
module mod_mul_pipe
    import kyber_pkg::*;
#(
    parameter int unsigned W       = KyberW,
    parameter int unsigned Q       = KyberQ,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] r
);

    localparam logic [2*W-1:0] QP   = (2*W)'(Q);
    // Barrett constant floor(2^(2W)/Q); the estimate is at most two multiples of Q short.
    localparam logic [4*W-1:0] MBAR = (4*W)'((64'd1 << (2*W)) / 64'(Q));

    function automatic logic [W-1:0] reduce(input logic [2*W-1:0] p);
        logic [4*W-1:0] wide;
        logic [2*W-1:0] qe;
        logic [2*W-1:0] rem;
        wide = {{(2*W){1'b0}}, p} * MBAR;
        qe   = wide[4*W-1:2*W];
        rem  = p - qe * QP;
        if (rem >= QP) begin
            rem = rem - QP;
        end
        if (rem >= QP) begin
            rem = rem - QP;
        end
        return rem[W-1:0];
    endfunction

    logic [2*W-1:0] prod;
    assign prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};

    if (MUL_LAT == 1) begin : g_single
        logic [W-1:0] r_q;

        // Single stage: multiply and reduce in one cycle.
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_q <= '0;
            end else if (en) begin
                r_q <= reduce(prod);
            end
        end

        assign r = r_q;
    end else begin : g_multi
        logic [2*W-1:0] p_q;
        logic [W-1:0]   d_q [MUL_LAT-1];

        // Product register, reduction register, then plain delay to reach MUL_LAT.
        always_ff @(posedge clk) begin
            if (!rst) begin
                p_q <= '0;
                for (int unsigned i = 0; i < MUL_LAT - 1; i++) begin
                    d_q[i] <= '0;
                end
            end else if (en) begin
                p_q    <= prod;
                d_q[0] <= reduce(p_q);
                for (int unsigned i = 1; i < MUL_LAT - 1; i++) begin
                    d_q[i] <= d_q[i-1];
                end
            end
        end

        assign r = d_q[MUL_LAT-2];
    end

endmodule

// File: rtl/butterfly_unit_p.sv
// Multi-lane Kyber butterfly: pre add/sub (S0), modular multiply (M), post add/sub (S1).
// Every mode traverses all stages, so latency is MUL_LAT+2 regardless of mode.
module butterfly_unit_p
    import kyber_pkg::*;
#(
    parameter int unsigned W       = KyberW,
    parameter int unsigned Q       = KyberQ,
    parameter int unsigned LANES   = 2,
    parameter int unsigned MUL_LAT = 3
) (
    input logic              clk,
    input logic              rst,
    butterfly_unit_p_if.slave bus
);

    localparam int unsigned DW = LANES * W;

    logic       advance;
    logic       s0_valid_q;
    mode_e      s0_mode_q;
    logic [MUL_LAT-1:0] m_valid_q;
    mode_e      m_mode_q [MUL_LAT];
    logic       out_valid_q;
    logic       s1_ntt;
    wire [DW-1:0] out1_w;
    wire [DW-1:0] out2_w;

    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance || !rst;
    assign s1_ntt       = (m_mode_q[MUL_LAT-1] == ModeNtt);

    // Valid bits and mode tags travel alongside the lane data; bubbles are kept, not collapsed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s0_valid_q  <= 1'b0;
            s0_mode_q   <= ModeNtt;
            m_valid_q   <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                m_mode_q[i] <= ModeNtt;
            end
            out_valid_q <= 1'b0;
        end else if (advance) begin
            s0_valid_q   <= bus.in_valid;
            s0_mode_q    <= bus.mode;
            m_valid_q[0] <= s0_valid_q;
            m_mode_q[0]  <= s0_mode_q;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                m_valid_q[i] <= m_valid_q[i-1];
                m_mode_q[i]  <= m_mode_q[i-1];
            end
            out_valid_q  <= m_valid_q[MUL_LAT-1];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [W-1:0] a, b, w;
        logic [W-1:0] sum, dif;
        logic [W-1:0] c_d, mx_d, my_d;
        logic [W-1:0] c_q, mx_q, my_q;
        logic [W-1:0] mc_q [MUL_LAT];
        logic [W-1:0] t;
        logic [W-1:0] o1_d, o2_d;
        logic [W-1:0] o1_q, o2_q;

        assign a = bus.in_a[k*W +: W];
        assign b = bus.in_b[k*W +: W];
        assign w = bus.coef[k*W +: W];

        // S0 operand selection: c bypasses the multiplier, mx*my goes through it.
        // ADDSUB routes a-b through the multiplier with y=1 to share the output path.
        always_comb begin
            sum = W'(mod_add(32'(a), 32'(b), Q));
            dif = W'(mod_sub(32'(a), 32'(b), Q));
            if (bus.mode == ModeIntt && bus.half) begin
                sum = W'(mod_half(32'(sum), Q));
                dif = W'(mod_half(32'(dif), Q));
            end
            c_d  = a;
            mx_d = b;
            my_d = w;
            case (bus.mode)
                ModeIntt: begin
                    c_d  = sum;
                    mx_d = dif;
                end
                ModeAddsub: begin
                    c_d  = sum;
                    mx_d = dif;
                    my_d = W'(1);
                end
                default: begin
                end
            endcase
        end

        // S0 register.
        always_ff @(posedge clk) begin
            if (!rst) begin
                c_q  <= '0;
                mx_q <= '0;
                my_q <= '0;
            end else if (advance) begin
                c_q  <= c_d;
                mx_q <= mx_d;
                my_q <= my_d;
            end
        end

        mod_mul_pipe #(
            .W       (W),
            .Q       (Q),
            .MUL_LAT (MUL_LAT)
        ) u_mul (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .x   (mx_q),
            .y   (my_q),
            .r   (t)
        );

        // Carry path delayed to line up with the multiplier result.
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int unsigned i = 0; i < MUL_LAT; i++) begin
                    mc_q[i] <= '0;
                end
            end else if (advance) begin
                mc_q[0] <= c_q;
                for (int unsigned i = 1; i < MUL_LAT; i++) begin
                    mc_q[i] <= mc_q[i-1];
                end
            end
        end

        // S1: NTT finishes with a+t / a-t; other modes pass carry and product through.
        always_comb begin
            o1_d = mc_q[MUL_LAT-1];
            o2_d = t;
            if (s1_ntt) begin
                o1_d = W'(mod_add(32'(mc_q[MUL_LAT-1]), 32'(t), Q));
                o2_d = W'(mod_sub(32'(mc_q[MUL_LAT-1]), 32'(t), Q));
            end
        end

        // S1 register, which is also the output register.
        always_ff @(posedge clk) begin
            if (!rst) begin
                o1_q <= '0;
                o2_q <= '0;
            end else if (advance) begin
                o1_q <= o1_d;
                o2_q <= o2_d;
            end
        end

        assign out1_w[k*W +: W] = o1_q;
        assign out2_w[k*W +: W] = o2_q;
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_1     = out1_w;
    assign bus.out_2     = out2_w;

endmodule

// File: tb/tb_butterfly_unit_p.sv
// Self-checking bench for butterfly_unit_p: arithmetic model + scoreboard, directed vectors.
module tb_butterfly_unit_p;
    import kyber_pkg::*;

    localparam int unsigned W       = 12;
    localparam int          Q       = 3329;
    localparam int unsigned LANES   = 2;
    localparam int unsigned MUL_LAT = 3;
    localparam int          L       = MUL_LAT + 2;
    localparam int unsigned DW      = LANES * W;

    typedef struct {
        logic [DW-1:0] o1;
        logic [DW-1:0] o2;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;
    exp_t exp_q[$];

    butterfly_unit_p_if #(.W(W), .LANES(LANES)) bus ();

    butterfly_unit_p #(
        .W       (W),
        .Q       (Q),
        .LANES   (LANES),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pack(input int l0, input int l1);
        logic [DW-1:0] v;
        v = '0;
        v[0 +: W] = W'(l0);
        v[W +: W] = W'(l1);
        return v;
    endfunction

    // Reference arithmetic with plain integers; halving uses the inverse of 2 mod Q.
    function automatic void model(input logic [1:0] m, input logic h,
                                  input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [DW-1:0] w,
                                  output logic [DW-1:0] o1, output logic [DW-1:0] o2);
        int inv2;
        inv2 = (Q + 1) / 2;
        o1 = '0;
        o2 = '0;
        for (int k = 0; k < LANES; k++) begin
            int ak, bk, wk, r1, r2, t;
            ak = int'(a[k*W +: W]);
            bk = int'(b[k*W +: W]);
            wk = int'(w[k*W +: W]);
            case (m)
                2'd0: begin
                    t  = (bk * wk) % Q;
                    r1 = (ak + t) % Q;
                    r2 = (ak - t + Q) % Q;
                end
                2'd1: begin
                    r1 = (ak + bk) % Q;
                    r2 = (ak - bk + Q) % Q;
                    if (h) begin
                        r1 = (r1 * inv2) % Q;
                        r2 = (r2 * inv2) % Q;
                    end
                    r2 = (r2 * wk) % Q;
                end
                2'd2: begin
                    r1 = ak;
                    r2 = (bk * wk) % Q;
                end
                default: begin
                    r1 = (ak + bk) % Q;
                    r2 = (ak - bk + Q) % Q;
                end
            endcase
            o1[k*W +: W] = W'(r1);
            o2[k*W +: W] = W'(r2);
        end
    endfunction

    // Scoreboard: push on accepted beats, pop and compare on delivered beats, check hold-stable.
    initial begin
        exp_t          e;
        logic          hold_v;
        logic [DW-1:0] hold_1, hold_2;
        hold_v = 1'b0;
        hold_1 = '0;
        hold_2 = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("hold_valid", int'(bus.out_valid), 1);
                    for (int k = 0; k < LANES; k++) begin
                        chk("hold_out_1", int'(bus.out_1[k*W +: W]), int'(hold_1[k*W +: W]));
                        chk("hold_out_2", int'(bus.out_2[k*W +: W]), int'(hold_2[k*W +: W]));
                    end
                end
                hold_v = bus.out_valid && !bus.out_ready;
                hold_1 = bus.out_1;
                hold_2 = bus.out_2;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("stray_beat", int'(bus.out_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        for (int k = 0; k < LANES; k++) begin
                            chk("out_1", int'(bus.out_1[k*W +: W]), int'(e.o1[k*W +: W]));
                            chk("out_2", int'(bus.out_2[k*W +: W]), int'(e.o2[k*W +: W]));
                        end
                        if (lat_chk) chk("latency", cyc - e.acc, L);
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    model(bus.mode, bus.half, bus.in_a, bus.in_b, bus.coef, e.o1, e.o2);
                    e.acc = cyc;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Present one beat and hold it until accepted; returns just after the accepting edge.
    task automatic drive(input logic [1:0] m, input logic h, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] w);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.mode     = mode_e'(m);
        bus.half     = h;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.coef     = w;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 1000);
        if (!acc) chk("drive_accept", int'(acc), 1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic rand_beat();
        drive(2'($urandom_range(3)), 1'($urandom_range(1)),
              pack($urandom_range(Q - 1), $urandom_range(Q - 1)),
              pack($urandom_range(Q - 1), $urandom_range(Q - 1)),
              pack($urandom_range(Q - 1), $urandom_range(Q - 1)));
    endtask

    initial begin
        logic [DW-1:0] o1, o2;
        int stray;
        bit rnd_done;

        bus.in_valid  = 1'b0;
        bus.mode      = ModeNtt;
        bus.half      = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.coef      = '0;
        bus.out_ready = 1'b1;

        // Pin the model against hand-computed values.
        model(2'd1, 1'b0, pack(5, 5), pack(3, 3), pack(17, 17), o1, o2);
        chk("pin_intt_o1", int'(o1[W-1:0]), 8);
        chk("pin_intt_o2", int'(o2[W-1:0]), 34);
        model(2'd1, 1'b1, pack(5, 3), pack(3, 5), pack(17, 17), o1, o2);
        chk("pin_intth_o1", int'(o1[W-1:0]), 4);
        chk("pin_intth_o2", int'(o2[W-1:0]), 17);
        chk("pin_intth_neg_o1", int'(o1[W +: W]), 4);
        chk("pin_intth_neg_o2", int'(o2[W +: W]), 3312);
        model(2'd2, 1'b1, pack(100, 0), pack(3328, 0), pack(3328, 0), o1, o2);
        chk("pin_mult_o1", int'(o1[W-1:0]), 100);
        chk("pin_mult_o2", int'(o2[W-1:0]), 1);
        model(2'd3, 1'b0, pack(3328, 0), pack(1, 0), pack(0, 0), o1, o2);
        chk("pin_addsub_o1", int'(o1[W-1:0]), 0);
        chk("pin_addsub_o2", int'(o2[W-1:0]), 3327);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_1", int'(bus.out_1), 0);
        chk("rst_out_2", int'(bus.out_2), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // Single NTT beat with literal expectations and exact latency.
        lat_chk = 1'b1;
        drive(2'd0, 1'b0, pack(1, 0), pack(2, 1), pack(17, 3328));
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
        chk("ntt_valid", int'(bus.out_valid), 1);
        chk("ntt_l0_o1", int'(bus.out_1[0 +: W]), 35);
        chk("ntt_l0_o2", int'(bus.out_2[0 +: W]), 3296);
        chk("ntt_l1_o1", int'(bus.out_1[W +: W]), 3328);
        chk("ntt_l1_o2", int'(bus.out_2[W +: W]), 1);
        drain();

        // Back-to-back mixed modes; latency check proves consecutive in-order delivery.
        drive(2'd0, 1'b0, pack(1, 0), pack(2, 1), pack(17, 3328));
        drive(2'd1, 1'b1, pack(5, 3), pack(3, 5), pack(17, 17));
        drive(2'd2, 1'b0, pack(100, 7), pack(3328, 3000), pack(3328, 2999));
        drive(2'd3, 1'b1, pack(3328, 0), pack(1, 3328), pack(5, 9));
        drive(2'd1, 1'b0, pack(5, 0), pack(3, 3328), pack(17, 1234));
        drain();
        lat_chk = 1'b0;

        // Stall with a full pipe: in_ready must drop and outputs must hold.
        fork
            begin
                for (int i = 0; i < 10; i++) rand_beat();
                bus.in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", int'(bus.in_ready), 0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // 64-beat random stream with random bubbles and backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    if ($urandom_range(3) == 0) idle(1);
                    rand_beat();
                end
                bus.in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) rand_beat();
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready_during", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_out_1", int'(bus.out_1), 0);
        chk("midrst_out_2", int'(bus.out_2), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        stray = 0;
        repeat (L + 3) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        chk("midrst_no_stale", stray, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
